seg7_scan_capture: RTL and testbench

//  Reader side of the multiplexed 7-segment display bus (active-low AN/SEG, {g,f,e,d,c,b,a}).

---
 rtl/seg7_scan_capture.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: reader for a multiplexed, active-low 7-segment display bus.
// It waits for each digit's AN/SEG lines to settle, decodes the segment pattern
// back to a hex nibble and rebuilds the multi-digit value.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   AN           anode lines, active-low (0 = digit selected)
//   SEG          segment lines, active-low {g,f,e,d,c,b,a}
//   VALUE        captured nibbles, digit i at VALUE[4i+3:4i]
//   DIGIT_VALID  bit i = digit i last captured as a legal hex pattern
//   FRAME_DONE   1-cycle pulse when every digit has been captured since the last pulse
//   SEG_ERR      1-cycle pulse on an illegal segment capture or a new multi-select
//   ERR_CNT      saturating SEG_ERR count (present only with SEG7_CAP_ERRCNT_EN)
//
// Build option: define SEG7_CAP_ERRCNT_EN to add the ERR_CNT port and counter.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   AN,
  input  logic [6:0]              SEG,
  output logic [4*NUM_DIGITS-1:0] VALUE,
  output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
  output logic                    FRAME_DONE,
  output logic                    SEG_ERR
`ifdef SEG7_CAP_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0]    ERR_CNT
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  state_t                st, st_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0] an_q, an_p, seen, seen_or;
  logic [6:0]            seg_q, seg_p;
  logic [IDX_W-1:0]      sel_idx;
  logic                  legal, multi, multi_p, changed, capture;
  logic                  dec_hit, cap_bad, seg_err_nxt;
  logic [3:0]            dec_code;

  function automatic int low_cnt(input logic [NUM_DIGITS-1:0] a);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!a[i]) n++;
    return n;
  endfunction

  // Exact-match hex decode; {hit, code}
  function automatic logic [4:0] hex_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return {1'b1, 4'h0};
      7'b1111001: return {1'b1, 4'h1};
      7'b0100100: return {1'b1, 4'h2};
      7'b0110000: return {1'b1, 4'h3};
      7'b0011001: return {1'b1, 4'h4};
      7'b0010010: return {1'b1, 4'h5};
      7'b0000010: return {1'b1, 4'h6};
      7'b1111000: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0010000: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b0000011: return {1'b1, 4'hB};
      7'b1000110: return {1'b1, 4'hC};
      7'b0100001: return {1'b1, 4'hD};
      7'b0000110: return {1'b1, 4'hE};
      7'b0001110: return {1'b1, 4'hF};
      default:    return 5'b0;
    endcase
  endfunction

  // Input register plus one cycle of history for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= '1;
      an_p  <= '1;
      seg_p <= '1;
    end else begin
      an_p  <= an_q;
      seg_p <= seg_q;
      an_q  <= AN;
      seg_q <= SEG;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!an_q[i]) sel_idx = IDX_W'(i);
  end

  assign legal   = (low_cnt(an_q) == 1);
  assign multi   = (low_cnt(an_q) > 1);
  assign multi_p = (low_cnt(an_p) > 1);
  assign changed = (an_q != an_p) || (seg_q != seg_p);
  assign {dec_hit, dec_code} = hex_decode(seg_q);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // FSM: next state. Reaching the settle count folds straight into CAPTURED,
  // which also covers SETTLE_CYCLES==1 (capture on the first settle edge).
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      IDLE: if (legal) begin
        st_nxt  = SETTLE;
        cnt_nxt = CNT_W'(1);
      end
      SETTLE: if (changed) begin
        st_nxt  = legal ? SETTLE : IDLE;
        cnt_nxt = CNT_W'(1);
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      CAPTURED: if (changed) begin
        st_nxt  = legal ? SETTLE : IDLE;
        cnt_nxt = CNT_W'(1);
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
      end
    endcase
    if (st_nxt == SETTLE && cnt_nxt == CNT_W'(SETTLE_CYCLES)) st_nxt = CAPTURED;
  end

  // FSM: outputs. CAPTURED->CAPTURED only happens via a recapture on change.
  always_comb begin
    capture     = (st_nxt == CAPTURED) && (st != CAPTURED || changed);
    cap_bad     = capture && !dec_hit && (seg_q != 7'h7F);
    seg_err_nxt = cap_bad || (multi && !multi_p);
    seen_or     = capture ? (seen | ~an_q) : seen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      VALUE       <= '0;
      DIGIT_VALID <= '0;
      FRAME_DONE  <= 1'b0;
      SEG_ERR     <= 1'b0;
      seen        <= '0;
    end else begin
      SEG_ERR    <= seg_err_nxt;
      FRAME_DONE <= capture && (&seen_or);
      seen       <= (capture && (&seen_or)) ? '0 : seen_or;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_idx == IDX_W'(i)) begin
          if (dec_hit) VALUE[4*i +: 4] <= dec_code;
          DIGIT_VALID[i] <= dec_hit;
        end
      end
    end
  end

`ifdef SEG7_CAP_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)                       ERR_CNT <= '0;
    else if (seg_err_nxt && ~&ERR_CNT) ERR_CNT <= ERR_CNT + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;
  localparam int ND = 8;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] AN;
  logic [6:0]    SEG;
  logic [4*ND-1:0] VALUE;
  logic [ND-1:0] DIGIT_VALID;
  logic          FRAME_DONE, SEG_ERR;
`ifdef SEG7_CAP_ERRCNT_EN
  logic [7:0]    ERR_CNT;
`endif

  seg7_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .AN(AN), .SEG(SEG),
    .VALUE(VALUE), .DIGIT_VALID(DIGIT_VALID),
    .FRAME_DONE(FRAME_DONE), .SEG_ERR(SEG_ERR)
`ifdef SEG7_CAP_ERRCNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_assert = 0;
  int n_fail   = 0;
  int fr_cnt   = 0;
  int er_cnt   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lows(input logic [ND-1:0] a);
    int n;
    n = 0;
    for (int i = 0; i < ND; i++) if (!a[i]) n++;
    return n;
  endfunction

  // Behavioural model: a digit is captured SETTLE cycles after a fresh,
  // single-select AN/SEG pair starts, provided it held unchanged that long.
  logic [4*ND-1:0] e_value;
  logic [ND-1:0]   e_valid, m_seen, m_an, m_an2;
  logic [6:0]      m_seg;
  logic            e_frame, e_err, m_live;
  int              e_cnt, m_run;

  initial begin
    m_live = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        e_value = '0; e_valid = '0; e_frame = 1'b0; e_err = 1'b0; e_cnt = 0;
        m_seen = '0; m_an = '1; m_an2 = '1; m_seg = '1; m_run = 1;
      end else begin
        e_frame = 1'b0;
        e_err   = (lows(m_an) > 1) && (lows(m_an2) <= 1);
        if (lows(m_an) == 1 && m_run == SC) begin
          int idx;
          int code;
          idx = 0;
          code = -1;
          for (int i = 0; i < ND; i++) if (!m_an[i]) idx = i;
          for (int k = 0; k < 16; k++) if (hex_tab[k] == m_seg) code = k;
          if (code >= 0) begin
            e_value[4*idx +: 4] = code[3:0];
            e_valid[idx] = 1'b1;
          end else begin
            e_valid[idx] = 1'b0;
            if (m_seg != 7'h7F) e_err = 1'b1;
          end
          m_seen[idx] = 1'b1;
          if (&m_seen) begin
            e_frame = 1'b1;
            m_seen  = '0;
          end
        end
        if (e_err && e_cnt < 255) e_cnt++;
        if (AN == m_an && SEG == m_seg) begin
          if (m_run < 1000) m_run++;
        end else m_run = 1;
        m_an2 = m_an;
        m_an  = AN;
        m_seg = SEG;
      end
      m_live = 1'b1;
    end
  end

  // Per-cycle comparison against the model, plus pulse counters
  initial begin
    forever begin
      @(negedge clk);
      if (FRAME_DONE) fr_cnt++;
      if (SEG_ERR)    er_cnt++;
      if (m_live) begin
        check("model VALUE", VALUE, e_value);
        check("model DIGIT_VALID", 32'(DIGIT_VALID), 32'(e_valid));
        check("model FRAME_DONE", 32'(FRAME_DONE), 32'(e_frame));
        check("model SEG_ERR", 32'(SEG_ERR), 32'(e_err));
`ifdef SEG7_CAP_ERRCNT_EN
        check("model ERR_CNT", 32'(ERR_CNT), 32'(e_cnt));
`endif
      end
    end
  end

  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    AN  = an;
    SEG = seg;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int f0, e0;
    AN = '1; SEG = '1; rst = 1'b1;
    // 1: reset
    repeat (3) @(negedge clk);
    check("reset VALUE", VALUE, 32'h0);
    check("reset DIGIT_VALID", 32'(DIGIT_VALID), 32'h0);
    check("reset pulses", 32'(fr_cnt + er_cnt), 32'h0);
    rst = 1'b0;

    // 2: capture latency is SETTLE+1 edges
    drive(8'hFE, 7'b0100100, 4);
    check("t2 not yet valid", 32'(DIGIT_VALID), 32'h00);
    drive(8'hFE, 7'b0100100, 1);
    check("t2 valid edge5", 32'(DIGIT_VALID), 32'h01);
    check("t2 nibble0", 32'(VALUE[3:0]), 32'h2);
    drive(8'hFE, 7'b0100100, 5);

    // 3: short glitch value is never captured
    drive(8'hFD, 7'b1111001, 2);
    check("t3 no glitch capture", 32'(VALUE[7:4]), 32'h0);
    drive(8'hFD, 7'b0110000, 6);
    check("t3 nibble1", 32'(VALUE[7:4]), 32'h3);

    // 4: full scan, one frame pulse
    f0 = fr_cnt;
    for (int i = 0; i < ND; i++) drive(~(8'h01 << i), hex_tab[i+1], 6);
    check("t4 VALUE", VALUE, 32'h87654321);
    check("t4 DIGIT_VALID", 32'(DIGIT_VALID), 32'hFF);
    check("t4 frame pulses", 32'(fr_cnt - f0), 32'h1);

    // 5: illegal pattern
    e0 = er_cnt;
    drive(8'hFB, 7'b0101010, 8);
    check("t5 err pulses", 32'(er_cnt - e0), 32'h1);
    check("t5 valid2", 32'(DIGIT_VALID[2]), 32'h0);
    check("t5 nibble2 kept", 32'(VALUE[11:8]), 32'h3);
`ifdef SEG7_CAP_ERRCNT_EN
    check("t5 ERR_CNT", 32'(ERR_CNT), 32'h1);
`endif

    // 6: multi-select, then idle bus
    e0 = er_cnt;
    drive(8'hFC, 7'b0101010, 6);
    check("t6 multi err pulses", 32'(er_cnt - e0), 32'h1);
    check("t6 VALUE kept", VALUE, 32'h87654321);
    e0 = er_cnt;
    drive(8'hFF, 7'h7F, 4);
    check("t6 idle no err", 32'(er_cnt - e0), 32'h0);

    // blank digit clears valid without error; letter decode
    e0 = er_cnt;
    drive(8'h7F, 7'h7F, 6);
    check("blank valid7", 32'(DIGIT_VALID[7]), 32'h0);
    check("blank nibble7 kept", 32'(VALUE[31:28]), 32'h8);
    check("blank no err", 32'(er_cnt - e0), 32'h0);
    drive(8'hBF, hex_tab[12], 6);
    check("letter C", 32'(VALUE[27:24]), 32'hC);

    // reset in the middle of a settle abandons the digit
    drive(8'hEF, hex_tab[10], 2);
    rst = 1'b1;
    drive(8'hEF, hex_tab[10], 1);
    rst = 1'b0;
    check("mid reset VALUE", VALUE, 32'h0);
    drive(8'hEF, hex_tab[10], 6);
    check("post reset VALUE", VALUE, 32'h000A0000);
    check("post reset valid", 32'(DIGIT_VALID), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
